// File: rtl/brq_ifu_fetch_fifo.sv
// brq_ifu_fetch_fifo: realigns word-aligned fetch responses into left-justified
// 16/32-bit instructions and tracks the fetch PC.
module brq_ifu_fetch_fifo #(
    parameter int unsigned NUM_REQS = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic [31:0] in_addr_i,
    input  logic        in_valid_i,
    input  logic [31:0] in_rdata_i,
    input  logic        in_err_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_addr_o,
    output logic [31:0] out_rdata_o,
    output logic        out_err_o,
    output logic        out_err_plus2_o,
    output logic        busy_o
);
    localparam int unsigned DEPTH = NUM_REQS + 1;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic [31:0]      r_data [DEPTH];
    logic [DEPTH-1:0] r_err;
    logic [CW-1:0]    r_cnt;
    logic [31:0]      r_pc;

    logic [31:0]      w_data_n [DEPTH];
    logic [DEPTH-1:0] w_err_n;
    logic [CW-1:0]    w_wr;
    logic w_v0, w_v1, w_e0, w_e1, w_unal, w_wide, w_fire, w_comp, w_pop, w_push;

    assign w_v0   = r_cnt != '0;
    assign w_v1   = r_cnt > CW'(1);
    assign w_e0   = r_err[0] & w_v0;
    assign w_e1   = r_err[1] & w_v1;
    assign w_unal = r_pc[1];
    // an unaligned 32-bit instruction straddles entry0 and entry1
    assign w_wide = w_unal & (r_data[0][17:16] == 2'b11);

    assign out_addr_o      = r_pc;
    assign out_rdata_o     = w_unal ? {r_data[1][15:0], r_data[0][31:16]} : r_data[0];
    assign out_valid_o     = w_v0 & (~w_wide | w_v1 | r_err[0]);
    assign out_err_o       = w_wide ? (w_e0 | w_e1) : w_e0;
    assign out_err_plus2_o = w_wide & w_e1 & ~w_e0;
    assign busy_o          = r_cnt >= CW'(DEPTH - 1);

    assign w_fire = out_valid_o & out_ready_i & ~clear_i;
    assign w_comp = out_rdata_o[1:0] != 2'b11;
    // an aligned compressed instruction leaves its upper half still in entry0
    assign w_pop  = w_fire & (w_unal | ~w_comp);
    assign w_push = in_valid_i & ~clear_i;
    assign w_wr   = r_cnt - CW'(w_pop);

    always_comb begin
        w_data_n = r_data;
        w_err_n  = r_err;
        if (w_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                w_data_n[i] = r_data[i+1];
                w_err_n[i]  = r_err[i+1];
            end
        end
        if (w_push) begin
            w_data_n[w_wr] = in_rdata_i;
            w_err_n[w_wr]  = in_err_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) r_data[i] <= '0;
            r_err <= '0;
            r_cnt <= '0;
            r_pc  <= '0;
        end else if (clear_i) begin
            r_cnt <= '0;
            r_pc  <= in_addr_i & ~32'd1;
        end else begin
            r_data <= w_data_n;
            r_err  <= w_err_n;
            r_cnt  <= r_cnt + CW'(w_push) - CW'(w_pop);
            if (w_fire) r_pc <= r_pc + (w_comp ? 32'd2 : 32'd4);
        end
    end

    assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(w_push && !w_pop && r_cnt == CW'(DEPTH)))
        else $error("push into full fetch fifo");
endmodule

// File: doc/brq_ifu_fetch_fifo.md
Name: brq_ifu_fetch_fifo

Overview:
- Instruction realignment FIFO in the IFU, between the instruction-memory response path and the compressed decoder.
- Buffers word-aligned 32-bit fetch responses and tracks the current PC.
- Presents one instruction per handshake, left-justified in a 32-bit word: either a full 32-bit instruction, possibly straddling two fetch words, or a 16-bit compressed instruction in bits [15:0].
- Advances its PC by 2 or 4 depending on the instruction's low two bits.

Parameters:
- NUM_REQS, 2, maximum outstanding fetch requests; FIFO depth DEPTH = NUM_REQS + 1 words.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- clear_i  input  1  flush all entries and load new PC (branch/exception redirect)
- in_addr_i  input  32  new PC, sampled only when clear_i=1
- in_valid_i  input  1  fetch response word valid
- in_rdata_i  input  32  fetch response word, from address in_addr word-aligned
- in_err_i  input  1  bus error on this fetch word
- out_valid_o  output  1  out_rdata_o holds a complete instruction
- out_ready_i  input  1  consumer accepts the instruction
- out_addr_o  output  32  PC of the presented instruction
- out_rdata_o  output  32  realigned instruction bits
- out_err_o  output  1  instruction fetch faulted
- out_err_plus2_o  output  1  fault lies only in the upper halfword (second fetch word)
- busy_o  output  1  count >= DEPTH-1; upstream stops issuing requests

Behaviour:
- Reset:
  - all entries invalid, count=0, PC=0.
  - out_valid_o=0, out_err_o=0, out_err_plus2_o=0, busy_o=0.
- Storage:
  - DEPTH entries {rdata[31:0], err}, shift-register or circular.
  - entry0 is the oldest.
- Push: in_valid_i & ~clear_i writes at tail.
  - Push when count==DEPTH and no pop in the same cycle is a protocol violation; assert it.
  - Push and pop in the same cycle are both honoured.
- Latency: registered, with no combinational bypass; pushed data is visible on outputs the following cycle at the earliest.
- Alignment is set by PC[1].
  - PC[1]=0: out_rdata_o = entry0.
    - out_valid_o = entry0 valid.
  - PC[1]=1: out_rdata_o = {entry1[15:0], entry0[31:16]}.
    - Compressed when entry0[17:16] != 2'b11; then out_valid_o = entry0 valid.
    - Otherwise out_valid_o = entry0 valid & (entry1 valid | entry0.err).
- out_rdata_o upper half is don't-care for compressed instructions; the decoder uses [15:0] only.
- Errors:
  - Aligned, or unaligned compressed: out_err_o = entry0.err.
  - Unaligned uncompressed: out_err_o = entry0.err | entry1.err, and out_err_plus2_o = entry1.err & ~entry0.err.
  - In all other cases out_err_plus2_o=0.
- Pop occurs on out_valid_o & out_ready_i. PC advances by 2 if out_rdata_o[1:0] != 2'b11, else by 4.
  - Aligned, uncompressed: pop entry0; PC[1] stays 0.
  - Aligned, compressed: no pop; PC[1] becomes 1.
  - Unaligned, compressed: pop entry0; PC[1] becomes 0.
  - Unaligned, uncompressed: pop entry0; PC[1] stays 1; entry1 becomes entry0.
- PC arithmetic is 32-bit modulo; 0xFFFF_FFFE+2 wraps to 0.
- clear_i:
  - Highest priority: invalidates all entries and sets PC = {in_addr_i[31:1],1'b0} next cycle.
  - in_valid_i and any pop in the same cycle are discarded.
  - out_valid_o is 0 in the cycle after clear_i.
  - The first word after clear_i is the word containing in_addr_i; if in_addr_i[1]=1, its lower half is skipped.
- busy_o is registered-equivalent of (count >= DEPTH-1) and is computed from the post-update count.
- Reset asserted mid-stream returns everything to reset values asynchronously.

Test Plan:
- Aligned stream: clear_i with addr 0x100; push 0x00A00093, 0x00100113 -> two instructions out at 0x100, 0x104 with rdata 0x00A00093, 0x00100113; out_err_o=0.
- Compressed pair: push 0x00050001 (c.nop, c.nop) -> out at 0x100 rdata[15:0]=0x0001, then at 0x102 rdata[15:0]=0x0005; one entry popped.
- Straddle: push 0x00934501, then 0x1234_00A0 -> c.li at 0x100, then 32-bit instruction at 0x102 = 0x00A00093. out_valid_o stays 0 until the second word arrives.
- Error-plus2: at PC 0x102 with entry0 upper half 0x0093 (uncompressed), second word pushed with in_err_i=1 -> out_valid_o=1, out_err_o=1, out_err_plus2_o=1.
- Flush: fill to DEPTH=3 (busy_o=1); assert clear_i with in_addr_i=0x202 and simultaneous in_valid_i -> next cycle count=0, out_valid_o=0, busy_o=0. The next push 0xAAAA0001 presents 0xAAAA at 0x202.
- Backpressure/concurrency: out_ready_i=0 for 3 cycles while pushing 2 words -> out_rdata_o stable. Then push and pop in the same cycle at count=2 -> count stays 2, order preserved.
